// File: rtl/adc_snapshot.sv
// Triggered two-channel snapshot buffer: captures {ch1, ch0} pairs into on-chip RAM
// after an immediate or rising level-crossing trigger, with optional decimation.
module adc_snapshot #(
    parameter int AW = 10,
    parameter int DW = 12
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   ch0_in,
    input  logic [DW-1:0]   ch1_in,
    input  logic            in_valid,
    input  logic            arm,
    input  logic            abort,
    input  logic            trig_mode,
    input  logic [DW-1:0]   trig_level,
    input  logic [7:0]      decim,
    input  logic [AW-1:0]   rd_addr,
    output logic [2*DW-1:0] rd_data,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_CAPTURE,
        S_DONE
    } state_e;

    // Count value at which the next write fills the last buffer entry.
    localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

    state_e          state_q, state_d;
    logic            done_q, done_d;
    logic [AW:0]     wr_count_q, wr_count_d;
    logic            hist_valid_q, hist_valid_d;
    logic [DW-1:0]   hist_q, hist_d;
    logic [7:0]      dec_cnt_q, dec_cnt_d;
    logic [7:0]      decim_q, decim_d;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            trig_hit;
    logic [2*DW-1:0] wr_data;
    logic [2*DW-1:0] rd_data_q;

    logic [2*DW-1:0] mem [2**AW];

    assign wr_data = {ch1_in, ch0_in};

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            wr_count_q   <= '0;
            hist_valid_q <= 1'b0;
            hist_q       <= '0;
            dec_cnt_q    <= '0;
            decim_q      <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            wr_count_q   <= wr_count_d;
            hist_valid_q <= hist_valid_d;
            hist_q       <= hist_d;
            dec_cnt_q    <= dec_cnt_d;
            decim_q      <= decim_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        wr_count_d   = wr_count_q;
        hist_valid_d = hist_valid_q;
        hist_d       = hist_q;
        dec_cnt_d    = dec_cnt_q;
        decim_d      = decim_q;
        wr_en        = 1'b0;
        wr_addr      = wr_count_q[AW-1:0];
        trig_hit     = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d      = S_WAIT_TRIG;
                        done_d       = 1'b0;
                        wr_count_d   = '0;
                        hist_valid_d = 1'b0;
                    end
                end
                S_WAIT_TRIG: begin
                    if (in_valid) begin
                        // The first sample after arming only seeds the crossing history.
                        trig_hit = !trig_mode ||
                                   (hist_valid_q && (hist_q < trig_level) && (ch0_in >= trig_level));
                        hist_d       = ch0_in;
                        hist_valid_d = 1'b1;
                        if (trig_hit) begin
                            wr_en      = 1'b1;
                            wr_addr    = '0;
                            wr_count_d = {{AW{1'b0}}, 1'b1};
                            dec_cnt_d  = decim;
                            decim_d    = decim;
                            state_d    = S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (in_valid) begin
                        if (dec_cnt_q == 8'd0) begin
                            wr_en      = 1'b1;
                            wr_count_d = wr_count_q + 1'b1;
                            dec_cnt_d  = decim_q;
                            if (wr_count_q == LAST_IDX) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            dec_cnt_d = dec_cnt_q - 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // RAM keeps its contents across reset; only the read register is cleared.
    always_ff @(posedge sys_clk) begin
        if (wr_en && rst_n) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data  = rd_data_q;
    assign busy     = (state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE);
    assign done     = done_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_adc_snapshot.sv
// Self-checking bench for adc_snapshot (AW=4): directed scenarios plus a randomized
// phase, all compared against a frame-level reference model.
module tb_adc_snapshot;

    localparam int AW    = 4;
    localparam int DW    = 12;
    localparam int DEPTH = 1 << AW;

    logic            sys_clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   ch0_in, ch1_in;
    logic            in_valid, arm, abort, trig_mode;
    logic [DW-1:0]   trig_level;
    logic [7:0]      decim;
    logic [AW-1:0]   rd_addr;
    logic [2*DW-1:0] rd_data;
    logic            busy, done;
    logic [AW:0]     wr_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: a frame is "waiting" or "capturing"; samples are kept when
    // their index since the trigger is a multiple of decim+1.
    bit              mWaiting, mCapturing, mDone, mHistValid, mRdKnown;
    int              mCount, mK, mDecim;
    logic [DW-1:0]   mHist;
    logic [2*DW-1:0] mRd;
    logic [2*DW-1:0] mMem [DEPTH];
    bit              mWritten [DEPTH];

    adc_snapshot #(.AW(AW), .DW(DW)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .ch0_in     (ch0_in),
        .ch1_in     (ch1_in),
        .in_valid   (in_valid),
        .arm        (arm),
        .abort      (abort),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .decim      (decim),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelWrite(input int addr);
        mMem[addr]     = {ch1_in, ch0_in};
        mWritten[addr] = 1'b1;
    endtask

    task automatic modelStep();
        logic [2*DW-1:0] nextRd;
        bit              nextKnown;
        bit              trig;
        nextRd    = mMem[rd_addr];
        nextKnown = mWritten[rd_addr];
        if (!rst_n) begin
            mWaiting = 0; mCapturing = 0; mDone = 0; mHistValid = 0;
            mCount = 0; nextRd = '0; nextKnown = 1;
        end else if (abort) begin
            mWaiting = 0; mCapturing = 0; mDone = 0;
        end else if (!mWaiting && !mCapturing) begin
            if (arm) begin
                mWaiting = 1; mDone = 0; mCount = 0; mHistValid = 0;
            end
        end else if (mWaiting) begin
            if (in_valid) begin
                trig = (trig_mode == 1'b0) ||
                       (mHistValid && (int'(mHist) < int'(trig_level)) && (int'(ch0_in) >= int'(trig_level)));
                mHist = ch0_in;
                mHistValid = 1;
                if (trig) begin
                    modelWrite(0);
                    mCount = 1; mK = 0; mDecim = int'(decim);
                    mWaiting = 0; mCapturing = 1;
                end
            end
        end else if (in_valid) begin
            mK++;
            if (mK % (mDecim + 1) == 0) begin
                modelWrite(mCount);
                mCount++;
                if (mCount == DEPTH) begin
                    mCapturing = 0; mDone = 1;
                end
            end
        end
        mRd      = nextRd;
        mRdKnown = nextKnown;
    endtask

    // Applies the given sample/control inputs for one cycle and compares afterwards.
    task automatic applyStimulus(input bit v, input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                 input bit a, input bit ab);
        in_valid = v; ch0_in = c0; ch1_in = c1; arm = a; abort = ab;
        modelStep();
        @(posedge sys_clk);
        #1;
        checkOutput("busy", 32'(busy), 32'(mWaiting || mCapturing));
        checkOutput("done", 32'(done), 32'(mDone));
        checkOutput("wr_count", 32'(wr_count), 32'(mCount));
        if (mRdKnown) checkOutput("rd_data", 32'(rd_data), 32'(mRd));
        arm = 0; abort = 0;
    endtask

    task automatic idle();
        applyStimulus(0, '0, '0, 0, 0);
    endtask

    initial begin
        int n;
        int validSeen;
        logic [DW-1:0] lvlSeq [5];

        for (int i = 0; i < DEPTH; i++) begin
            mMem[i] = '0; mWritten[i] = 0;
        end
        mWaiting = 0; mCapturing = 0; mDone = 0; mHistValid = 0; mRdKnown = 0;
        mCount = 0; mK = 0; mDecim = 0; mHist = '0; mRd = '0;
        rst_n = 0; in_valid = 0; ch0_in = '0; ch1_in = '0; arm = 0; abort = 0;
        trig_mode = 0; trig_level = '0; decim = '0; rd_addr = '0;

        // Reset state
        idle();
        idle();
        checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
        checkOutput("reset_wr_count", 32'(wr_count), 32'h0);
        rst_n = 1;
        idle();

        // Immediate trigger, ramp
        $display("[TB] immediate trigger");
        trig_mode = 0; decim = 0;
        applyStimulus(1, 12'h7AA, 12'h123, 1, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 12'(i), 12'(12'hFFF - i), 0, 0);
        checkOutput("imm_done", 32'(done), 32'h1);
        checkOutput("imm_count", 32'(wr_count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = 4'(i);
            idle();
            checkOutput("imm_rd", 32'(rd_data), 32'({12'(12'hFFF - i), 12'(i)}));
        end

        // Level trigger
        $display("[TB] level trigger");
        trig_mode = 1; trig_level = 12'h800;
        lvlSeq[0] = 12'h900; lvlSeq[1] = 12'h7F0; lvlSeq[2] = 12'h7FF;
        lvlSeq[3] = 12'h800; lvlSeq[4] = 12'h810;
        applyStimulus(0, '0, '0, 1, 0);
        applyStimulus(1, lvlSeq[0], 12'h001, 0, 0);
        checkOutput("lvl_first_no_trig", 32'(wr_count), 32'h0);
        applyStimulus(1, lvlSeq[1], 12'h002, 0, 0);
        applyStimulus(1, lvlSeq[2], 12'h003, 0, 0);
        applyStimulus(1, lvlSeq[3], 12'h004, 0, 0);
        checkOutput("lvl_trig_count", 32'(wr_count), 32'h1);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1, 12'(lvlSeq[4] + i), 12'h005, 0, 0);
        checkOutput("lvl_done", 32'(done), 32'h1);
        rd_addr = '0;
        idle();
        checkOutput("lvl_addr0_ch0", 32'(rd_data[DW-1:0]), 32'h800);

        // Decimation with gaps; decim change mid-frame is ignored
        $display("[TB] decimation");
        trig_mode = 0; decim = 8'd2;
        applyStimulus(0, '0, '0, 1, 0);
        validSeen = 0;
        n = 0;
        while (validSeen < 1 + (DEPTH - 1) * 3 && n < 300) begin
            if (validSeen == 10) decim = 8'd5;
            if ($urandom_range(3) != 0) begin
                applyStimulus(1, 12'(12'h100 + validSeen), 12'(12'h100 + validSeen) ^ 12'hA5A, 0, 0);
                validSeen++;
            end else begin
                applyStimulus(0, 12'hFFF, 12'hFFF, 0, 0);
            end
            n++;
        end
        checkOutput("dec_done", 32'(done), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = 4'(i);
            idle();
            checkOutput("dec_rd", 32'(rd_data), 32'({12'(12'h100 + 3 * i) ^ 12'hA5A, 12'(12'h100 + 3 * i)}));
        end

        // Abort mid-capture; arm+abort together
        $display("[TB] abort");
        decim = 0;
        applyStimulus(0, '0, '0, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 12'(i + 40), 12'h0AB, 0, 0);
        checkOutput("abort_pre_count", 32'(wr_count), 32'h5);
        applyStimulus(1, 12'h055, 12'h0AB, 0, 1);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_done", 32'(done), 32'h0);
        checkOutput("abort_count", 32'(wr_count), 32'h5);
        applyStimulus(1, 12'h056, 12'h0AB, 1, 1);
        checkOutput("arm_abort_busy", 32'(busy), 32'h0);
        applyStimulus(1, 12'h057, 12'h0AB, 0, 0);

        // Rearm after done, arm ignored in capture, reset mid-capture
        $display("[TB] rearm and reset");
        applyStimulus(0, '0, '0, 1, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 12'(i + 200), 12'h321, 0, 0);
        checkOutput("rearm_pre_done", 32'(done), 32'h1);
        applyStimulus(0, '0, '0, 1, 0);
        checkOutput("rearm_done", 32'(done), 32'h0);
        checkOutput("rearm_count", 32'(wr_count), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 12'(i + 300), 12'h456, 0, 0);
        applyStimulus(1, 12'h3FF, 12'h456, 1, 0);
        checkOutput("arm_in_capture_count", 32'(wr_count), 32'h4);
        rd_addr = 4'd1;
        rst_n = 0;
        applyStimulus(1, 12'h400, 12'h456, 0, 0);
        rst_n = 1;
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_count", 32'(wr_count), 32'h0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'h0);

        // Randomized traffic against the model
        $display("[TB] random");
        for (int i = 0; i < 1500; i++) begin
            trig_mode  = 1'($urandom_range(1));
            trig_level = 12'($urandom_range(12'hC00, 12'h400));
            decim      = 8'($urandom_range(2));
            rd_addr    = 4'($urandom);
            rst_n      = ($urandom_range(299) != 0);
            applyStimulus($urandom_range(3) != 0, 12'($urandom), 12'($urandom),
                          $urandom_range(19) == 0, $urandom_range(99) == 0);
        end
        rst_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_snapshot.md
# adc_snapshot

Triggered two-channel snapshot buffer that sits directly downstream of the `adc` capture stage in `adc_dac`. It takes the 12-bit per-channel samples produced on `sys_clk`, optionally decimates them, and on an immediate or level-crossing trigger fills an on-chip RAM with {ch1, ch0} pairs. The SoC (CSR bridge) then reads the frame back through an independent read port for scope-style inspection.

## Interface
- `AW`, default 10: log2 of buffer depth; the buffer holds 2^AW entries.
- `DW`, default 12: ADC sample width per channel.
- `sys_clk`  in  1  single clock for all logic and both RAM ports.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `sys_clk` rising edge.
- `ch0_in`  in  DW  channel 0 sample, offset-binary.
- `ch1_in`  in  DW  channel 1 sample, offset-binary.
- `in_valid`  in  1  qualifies `ch0_in`/`ch1_in` this cycle.
- `arm`  in  1  single-cycle pulse that starts a capture.
- `abort`  in  1  single-cycle pulse that stops any capture and returns to IDLE.
- `trig_mode`  in  1  0 = immediate trigger, 1 = rising level crossing on ch0.
- `trig_level`  in  DW  crossing threshold, unsigned compare.
- `decim`  in  8  store 1 of every `decim`+1 valid samples; 0 stores every sample.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  2*DW  {ch1, ch0} at `rd_addr`.
- `busy`  out  1  high in WAIT_TRIG or CAPTURE.
- `done`  out  1  frame complete; sticky until the next `arm` or `abort`.
- `wr_count`  out  AW+1  number of entries written in the current frame.

## Operation
- **States**: IDLE, WAIT_TRIG, CAPTURE, DONE.
  - IDLE or DONE, on `arm`: go to WAIT_TRIG. Clear `done` and `wr_count`, and invalidate the crossing history.
  - WAIT_TRIG, mode 0: the first `in_valid` sample is the trigger.
  - WAIT_TRIG, mode 1: a valid sample triggers when the previous valid sample in WAIT_TRIG was below `trig_level` (prev < `trig_level`) and the current one is at or above it (cur >= `trig_level`).
    - The first valid sample after entering WAIT_TRIG only loads the history and can never trigger.
- **On trigger**:
  - The triggering pair is written to address 0 and `wr_count` becomes 1.
  - The decimation counter loads `decim` and the state goes to CAPTURE.
- **CAPTURE**:
  - Each valid sample with a decimation counter of 0 is written at address `wr_count`; `wr_count` increments and the counter reloads `decim`.
  - Otherwise a valid sample only decrements the counter.
  - `decim` is sampled at the trigger; changes mid-frame are ignored.
  - After the write that makes `wr_count` = 2^AW, go to DONE and set `done`.
- **Abort and arm conflicts**:
  - `abort` in any state: go to IDLE, leaving `done` = 0 and `wr_count` unchanged.
  - `abort` wins over a simultaneous `arm`.
  - `arm` in WAIT_TRIG or CAPTURE is ignored.
- **Read port**:
  - Free-running with a registered output, so `rd_data` reflects the `rd_addr` presented on the previous cycle.
  - Reads are legal in every state. A read and a write to the same address in the same cycle returns the old contents.
  - RAM contents are not cleared by reset or `arm`.
- `trig_level` and `trig_mode` are used combinationally in WAIT_TRIG and may change between frames.
- `in_valid` low: no state, counter or history update, except `arm`/`abort` handling.

## Timing
- **Reset values**: `busy` = 0, `done` = 0, `wr_count` = 0, `rd_data` = 0, state IDLE, history invalid, decimation counter 0.
- `arm` in cycle t: `busy` = 1 from t+1. A valid sample in t itself is not considered.
- **Trigger**:
  - A trigger sample in cycle t is written at the t edge.
  - State is CAPTURE and `wr_count` = 1 from t+1.
- **Writes**: each write in cycle t makes `wr_count` increment visible at t+1.
- **Last write** in cycle t: from t+1, `done` = 1, `busy` = 0 and `wr_count` = 2^AW.
- **Read latency**: 1 cycle, address to data.
- **Throughput**: `in_valid` may be high every cycle; no backpressure exists and samples are never stalled.

## Test plan
- **Immediate trigger**: AW=4, decim=0, mode 0, ramp ch0 = 0,1,2,…, ch1 = 0xFFF−ch0, valid every cycle, arm.
  - After 16 valid samples, `done` = 1 and `wr_count` = 16.
  - Reading addresses 0..15 returns {0xFFF−n, n} with 1-cycle latency.
- **Level trigger**: mode 1, `trig_level` = 0x800, ch0 sequence 0x900, 0x7F0, 0x7FF, 0x800, 0x810…
  - Address 0 holds ch0 = 0x800.
  - The first sample 0x900 does not trigger.
- **Decimation**: decim = 2, ch0 ramp starting at 0x100 at the trigger.
  - Stored ch0 = 0x100, 0x103, 0x106, …
  - Gaps in `in_valid` do not change the stored sequence.
- **Abort mid-capture**: abort when `wr_count` = 5.
  - Next cycle: IDLE, `busy` = 0, `done` = 0, `wr_count` = 5.
  - A simultaneous `arm` + `abort` leaves the block in IDLE.
- **Rearm after done, and reset mid-capture**:
  - `arm` in DONE clears `done` and `wr_count` next cycle.
  - `rst_n` low for 1 cycle during CAPTURE sets all outputs to reset values, including `rd_data` = 0.
  - An `arm` during CAPTURE is ignored (`wr_count` keeps counting).
